uart_rx_deser: RTL
==================

Name: uart_rx_deser

Overview:
- UART receive front end of the tt_uart_fifo design. It deserialises the 8N1 serial line from the RX pin into bytes.
- Each byte is presented on a valid/ready stream that feeds the receive FIFO write port.
- It synchronises the asynchronous line, rejects start-bit glitches, and flags framing errors and overruns.
- Sits directly upstream of the FIFO; the FIFO drives m_ready from its not-full status.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200 baud). Legal range is at least 4; the half-bit point is CLKS_PER_BIT/2, integer-truncated.
- CNT_W, $clog2(CLKS_PER_BIT), width of the bit-timing counter. Derived; not overridden.

Ports:
- clk  in  1  system clock; all flops rising-edge.
- rst  in  1  asynchronous active-high reset.
- rx_i  in  1  raw serial line; idle high; asynchronous to clk.
- m_data  out  8  received byte, LSB is the first bit on the wire.
- m_valid  out  1  m_data holds an undelivered byte.
- m_ready  in  1  consumer (FIFO) accepts m_data this cycle.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: completed byte dropped because the holding register was still occupied.

Behaviour:
- Reset (async assert, sync-safe release):
  - rx synchroniser flops = 1, FSM = IDLE, counter = 0, bit index = 0, shift register = 0.
  - m_data = 0x00, m_valid = 0, frame_err = 0, overrun = 0.
  - Reset mid-frame abandons the frame silently with no error pulse.
- Synchroniser: 2-flop chain on rx_i; rx_s is the second flop. All decisions use rx_s, which adds 2 cycles of latency.
- FSM states are IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when rx_s == 0, go to START with counter = 0.
  - START: counter increments. At counter == CLKS_PER_BIT/2 - 1, sample rx_s:
    - 0: go to DATA with counter = 0 and bit index = 0.
    - 1: glitch; return to IDLE with no output.
  - DATA: at counter == CLKS_PER_BIT - 1, sample rx_s into the shift register (shift right, insert at bit 7) and reset the counter. When bit index reaches 7 after its sample, go to STOP; otherwise increment bit index.
  - STOP: at counter == CLKS_PER_BIT - 1, sample rx_s, which is the mid-stop-bit point:
    - 1: byte complete; go to IDLE.
    - 0: frame_err pulses for one cycle, byte discarded, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s == 1, then go to IDLE. A held-low break therefore does not retrigger.
- Output holding register:
  - On byte complete with m_valid == 0: load m_data and set m_valid = 1 on the next edge.
  - Transfer occurs when m_valid && m_ready; m_valid clears next cycle unless a new byte loads in the same cycle.
  - Simultaneous complete and transfer: the new byte loads, m_valid stays 1, no overrun.
  - Complete while m_valid && !m_ready: new byte dropped, old m_data retained, overrun pulses for one cycle.
  - m_data is stable while m_valid && !m_ready.
  - A framing error never touches m_data or m_valid.
- Timing: from the first cycle rx_s is low in IDLE, the byte-complete sample occurs at cycle CLKS_PER_BIT/2 + 9*CLKS_PER_BIT. m_valid rises one cycle later.
- Back-to-back frames: returning to IDLE at mid-stop leaves half a bit to catch the next start edge, so no inter-frame gap is required.

Test Plan (CLKS_PER_BIT=16 override, m_ready=1 unless stated):
- Single byte 0xA5, 8N1 → m_valid rises 155±2 cycles after the rx_i falling edge with m_data = 0xA5; frame_err and overrun stay 0.
- rx_i low for 4 cycles, then high → no m_valid and no frame_err. A following 0x3C frame is received as 0x3C.
- 0x55 frame with stop bit driven 0 for 2 bit times, then line high → exactly one frame_err pulse and m_valid stays 0. A following 0x0F frame is received as 0x0F.
- m_ready = 0; send 0x11 then 0x22 → m_valid = 1 holding 0x11 throughout; one overrun pulse at the second frame's stop sample. Then raise m_ready → 0x11 is taken once and m_valid falls next cycle.
- Assert rst during data bit 3 of a frame → all outputs 0 within the same cycle and no pulses. After release, a 0x80 frame is received as 0x80.
- Back-to-back 0x00 then 0xFF with no idle gap → two transfers, 0x00 then 0xFF, 160±2 cycles apart, with no errors.

Source files
------------

// File: rtl/uart_rx_deser.sv
// UART 8N1 receive deserialiser: synchronises rx_i, times bits from the start edge and
// presents each byte on a valid/ready holding register with framing-error and overrun pulses.
module uart_rx_deser #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  localparam logic [CNT_W-1:0] CntHalf = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CntFull = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta_q, rx_s_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             byte_done;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    byte_done   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          cnt_d   = '0;
        end
      end
      StStart: begin
        // Mid-start-bit check: a line already back high was only a glitch.
        if (cnt_q == CntHalf) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          state_d   = rx_s_q ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StData: begin
        if (cnt_q == CntFull) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StStop: begin
        if (cnt_q == CntFull) begin
          cnt_d = '0;
          if (rx_s_q) begin
            byte_done = 1'b1;
            state_d   = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitHigh;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWaitHigh: begin
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // A completing byte may reuse the slot in the same cycle it is drained.
    if (byte_done) begin
      if (!m_valid_q || m_ready) begin
        m_data_d  = shift_q;
        m_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      m_data_q    <= 8'h00;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= rx_i;
      rx_s_q      <= rx_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
